dccm_ctrl: RTL and testbench
============================

Name: dccm_ctrl

Overview:
Data closely-coupled memory (DCCM) controller that sits directly downstream of the LSU and serves the LSU read/write interface from an internal 1R1W word array. It also arbitrates a secondary valid/ready DMA/debug port, used for preload and inspection, onto whichever array port the LSU leaves idle. The LSU always has priority and is never stalled.

Parameters:
XLEN, 32, data and address width.
DCCM_BASE, 32'h0001_0000, byte base address of the DCCM window.
DCCM_DEPTH, 4096, number of XLEN-bit words; must be a power of 2.
STARVE_LIMIT, 16, number of cycles a DMA request may wait before dma_starve asserts.

Ports:
clk  in  1  core clock.
rstn  in  1  active-low reset.
lsu_dccm_raddr  in  XLEN  word-aligned read address.
lsu_dccm_rvalid_in  in  1  LSU read request.
lsu_dccm_rdata  out  XLEN  read data.
lsu_dccm_rvalid_out  out  1  read data valid.
lsu_dccm_waddr  in  XLEN  word-aligned write address.
lsu_dccm_wen  in  1  LSU full-word write enable.
lsu_dccm_wdata  in  XLEN  write data.
lsu_dccm_err  out  1  LSU access out of range, pulsed.
dma_req_valid  in  1  DMA request valid.
dma_req_ready  out  1  DMA request accepted this cycle.
dma_req_we  in  1  1 = write, 0 = read.
dma_req_addr  in  XLEN  DMA byte address; bits [1:0] ignored.
dma_req_wdata  in  XLEN  DMA write data.
dma_rsp_valid  out  1  DMA response valid, one per accepted request.
dma_rsp_rdata  out  XLEN  DMA read data; 0 for writes.
dma_rsp_err  out  1  DMA address out of range.
dma_starve  out  1  DMA request has waited at least STARVE_LIMIT cycles.

Behaviour:
- Reset is asynchronous and active-low.
  - All outputs reset to 0.
  - Starvation counter resets to 0.
  - Array contents are not reset.
- Address decode:
  - An access is in range when (addr - DCCM_BASE) < DCCM_DEPTH*4.
  - Word index = (addr - DCCM_BASE)[log2(DCCM_DEPTH)+1:2].
- LSU read:
  - rvalid_in in cycle N gives rvalid_out=1 in cycle N+1, with rdata = array[idx] as sampled in cycle N.
  - Reads are read-first: a same-cycle write to the same index is not visible to the read. The LSU does its own forwarding.
  - rdata holds its last value while rvalid_out=0.
  - An out-of-range read gives rvalid_out=1, rdata=0 and err=1 in N+1.
- LSU write:
  - wen in cycle N updates the array at the clk edge ending cycle N.
  - An out-of-range write is dropped and gives err=1 in N+1.
  - If a read and a write are both out of range in the same cycle, a single err pulse is produced.
- DMA arbitration, fixed LSU priority:
  - DMA read: dma_req_ready = dma_req_valid & ~lsu_dccm_rvalid_in.
  - DMA write: dma_req_ready = dma_req_valid & ~lsu_dccm_wen.
  - ready is combinational, and the request is accepted when valid & ready.
  - The DMA response comes one cycle after acceptance, with the same read-first and error rules as the LSU.
  - Responses do not back-pressure.
  - At most one DMA request is accepted per cycle.
- Write collision: an LSU write and a DMA write can never land in the same cycle.
- Starvation counter:
  - Increments while valid & ~ready, saturating at STARVE_LIMIT.
  - Clears on acceptance or when valid is deasserted.
  - dma_starve = (count == STARVE_LIMIT).
  - dma_starve is status only and never stalls the LSU.
- Reset mid-operation: any pending rvalid_out or dma_rsp_valid is cancelled; responses never appear after reset.

Decomposition:
- Shared package holds DCCM_BASE, DCCM_DEPTH and the decode helper function dccm_in_range.
- Sub-module dccm_ram is a behavioural 1R1W array with a registered read port and no reset. It is instantiated once.
- dccm_ctrl contains the decode, arbitration, response pipeline and starvation counter.

Test Plan:
- DMA write of 32'hDEADBEEF to DCCM_BASE+8, then LSU rvalid_in with raddr=DCCM_BASE+8 -> rvalid_out=1 exactly one cycle later with rdata=32'hDEADBEEF.
- Same-cycle LSU wen (wdata=32'h1234_5678) and rvalid_in to the same word, old contents 32'hA5A5A5A5 -> rdata=32'hA5A5A5A5; a read in the next cycle returns 32'h12345678.
- LSU rvalid_in held high for 20 cycles while a DMA read is pending -> dma_req_ready=0 throughout; dma_starve rises after the 16th waiting cycle; the request is accepted the cycle rvalid_in drops and dma_rsp_valid follows one cycle later.
- LSU read of DCCM_BASE+DCCM_DEPTH*4 -> lsu_dccm_err=1, rdata=0, rvalid_out=1; an LSU write to the same address leaves the array unchanged when checked by DMA read.
- LSU wen active while DMA issues a read -> DMA is accepted in the same cycle and the LSU write completes; no lost write.
- rstn asserted the cycle after an accepted DMA read -> dma_rsp_valid stays 0 and all outputs read 0 during reset.

Source files
------------

// File: rtl/dccm_pkg.sv
// rtl/dccm_pkg.sv - DCCM window constants and address decode helpers
package dccm_pkg;

    localparam int unsigned DCCM_XLEN    = 32;
    localparam logic [31:0] DCCM_BASE    = 32'h0001_0000;
    localparam int unsigned DCCM_DEPTH   = 4096;
    localparam int unsigned STARVE_LIMIT = 16;

    function automatic logic [31:0] dccm_offset(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

    // Offset is unsigned, so addresses below the base wrap high and fall out of range.
    function automatic logic dccm_in_range(input logic [31:0] offset, input int unsigned depth);
        return offset < (depth << 2);
    endfunction

endpackage

// File: rtl/dccm_ram.sv
// rtl/dccm_ram.sv - 1R1W word array with registered, read-first read port
module dccm_ram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/dccm_ctrl.sv
// rtl/dccm_ctrl.sv - DCCM controller: LSU port with fixed priority, DMA port on idle array ports
module dccm_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] DCCM_BASE    = dccm_pkg::DCCM_BASE,
    parameter int unsigned DCCM_DEPTH   = dccm_pkg::DCCM_DEPTH,
    parameter int unsigned STARVE_LIMIT = dccm_pkg::STARVE_LIMIT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] lsu_dccm_raddr,
    input  logic            lsu_dccm_rvalid_in,
    output logic [XLEN-1:0] lsu_dccm_rdata,
    output logic            lsu_dccm_rvalid_out,
    input  logic [XLEN-1:0] lsu_dccm_waddr,
    input  logic            lsu_dccm_wen,
    input  logic [XLEN-1:0] lsu_dccm_wdata,
    output logic            lsu_dccm_err,
    input  logic            dma_req_valid,
    output logic            dma_req_ready,
    input  logic            dma_req_we,
    input  logic [XLEN-1:0] dma_req_addr,
    input  logic [XLEN-1:0] dma_req_wdata,
    output logic            dma_rsp_valid,
    output logic [XLEN-1:0] dma_rsp_rdata,
    output logic            dma_rsp_err,
    output logic            dma_starve
);
    import dccm_pkg::*;

    localparam int unsigned AW = $clog2(DCCM_DEPTH);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [XLEN-1:0] w_lsu_roff;
    logic [XLEN-1:0] w_lsu_woff;
    logic [XLEN-1:0] w_dma_off;
    logic            w_lsu_rd_ok;
    logic            w_lsu_wr_ok;
    logic            w_dma_ok;
    logic            w_dma_accept;

    logic            w_ram_we;
    logic [AW-1:0]   w_ram_waddr;
    logic [XLEN-1:0] w_ram_wdata;
    logic            w_ram_re;
    logic [AW-1:0]   w_ram_raddr;
    logic [XLEN-1:0] w_ram_q;

    logic            r_lsu_rvalid;
    logic            r_lsu_rd_zero;
    logic [XLEN-1:0] r_lsu_rdata_hold;
    logic            r_lsu_err;
    logic            r_dma_rsp_valid;
    logic            r_dma_rsp_rd;
    logic            r_dma_rsp_err;
    logic [CW-1:0]   r_starve_cnt;

    assign w_lsu_roff  = dccm_offset(lsu_dccm_raddr, DCCM_BASE);
    assign w_lsu_woff  = dccm_offset(lsu_dccm_waddr, DCCM_BASE);
    assign w_dma_off   = dccm_offset(dma_req_addr, DCCM_BASE);
    assign w_lsu_rd_ok = dccm_in_range(w_lsu_roff, DCCM_DEPTH);
    assign w_lsu_wr_ok = dccm_in_range(w_lsu_woff, DCCM_DEPTH);
    assign w_dma_ok    = dccm_in_range(w_dma_off, DCCM_DEPTH);

    // DMA only borrows the array port the LSU leaves idle this cycle.
    assign dma_req_ready = rstn & dma_req_valid &
                           (dma_req_we ? ~lsu_dccm_wen : ~lsu_dccm_rvalid_in);
    assign w_dma_accept  = dma_req_ready;

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = w_lsu_woff[AW+1:2];
        w_ram_wdata = lsu_dccm_wdata;
        w_ram_re    = 1'b0;
        w_ram_raddr = w_lsu_roff[AW+1:2];
        if (rstn && lsu_dccm_wen) begin
            w_ram_we = w_lsu_wr_ok;
        end else if (w_dma_accept && dma_req_we) begin
            w_ram_we    = w_dma_ok;
            w_ram_waddr = w_dma_off[AW+1:2];
            w_ram_wdata = dma_req_wdata;
        end
        if (rstn && lsu_dccm_rvalid_in) begin
            w_ram_re = w_lsu_rd_ok;
        end else if (w_dma_accept && !dma_req_we) begin
            w_ram_re    = w_dma_ok;
            w_ram_raddr = w_dma_off[AW+1:2];
        end
    end

    dccm_ram #(
        .DW    (XLEN),
        .DEPTH (DCCM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lsu_rvalid     <= 1'b0;
            r_lsu_rd_zero    <= 1'b0;
            r_lsu_rdata_hold <= '0;
            r_lsu_err        <= 1'b0;
            r_dma_rsp_valid  <= 1'b0;
            r_dma_rsp_rd     <= 1'b0;
            r_dma_rsp_err    <= 1'b0;
            r_starve_cnt     <= '0;
        end else begin
            r_lsu_rvalid     <= lsu_dccm_rvalid_in;
            r_lsu_rd_zero    <= lsu_dccm_rvalid_in & ~w_lsu_rd_ok;
            r_lsu_rdata_hold <= lsu_dccm_rdata;
            r_lsu_err        <= (lsu_dccm_rvalid_in & ~w_lsu_rd_ok) |
                                (lsu_dccm_wen & ~w_lsu_wr_ok);
            r_dma_rsp_valid  <= w_dma_accept;
            r_dma_rsp_rd     <= w_dma_accept & ~dma_req_we & w_dma_ok;
            r_dma_rsp_err    <= w_dma_accept & ~w_dma_ok;
            if (!dma_req_valid || w_dma_accept) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != CW'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + CW'(1);
            end
        end
    end

    // Read data is shown only in the valid cycle, then the register keeps it stable.
    assign lsu_dccm_rdata      = r_lsu_rvalid ? (r_lsu_rd_zero ? '0 : w_ram_q) : r_lsu_rdata_hold;
    assign lsu_dccm_rvalid_out = r_lsu_rvalid;
    assign lsu_dccm_err        = r_lsu_err;
    assign dma_rsp_valid       = r_dma_rsp_valid;
    assign dma_rsp_rdata       = r_dma_rsp_rd ? w_ram_q : '0;
    assign dma_rsp_err         = r_dma_rsp_err;
    assign dma_starve          = (r_starve_cnt == CW'(STARVE_LIMIT));

endmodule

// File: tb/tb_dccm_ctrl.sv
// tb/tb_dccm_ctrl.sv - self-checking bench for dccm_ctrl with a behavioural memory model
module tb_dccm_ctrl;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 4096;
    localparam int          LIMIT = 16;
    localparam logic [31:0] OOR   = BASE + DEPTH * 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] lsu_dccm_raddr;
    logic        lsu_dccm_rvalid_in;
    logic [31:0] lsu_dccm_rdata;
    logic        lsu_dccm_rvalid_out;
    logic [31:0] lsu_dccm_waddr;
    logic        lsu_dccm_wen;
    logic [31:0] lsu_dccm_wdata;
    logic        lsu_dccm_err;
    logic        dma_req_valid;
    logic        dma_req_ready;
    logic        dma_req_we;
    logic [31:0] dma_req_addr;
    logic [31:0] dma_req_wdata;
    logic        dma_rsp_valid;
    logic [31:0] dma_rsp_rdata;
    logic        dma_rsp_err;
    logic        dma_starve;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_hold;

    always #5 clk = ~clk;

    dccm_ctrl dut (
        .clk                 (clk),
        .rstn                (rstn),
        .lsu_dccm_raddr      (lsu_dccm_raddr),
        .lsu_dccm_rvalid_in  (lsu_dccm_rvalid_in),
        .lsu_dccm_rdata      (lsu_dccm_rdata),
        .lsu_dccm_rvalid_out (lsu_dccm_rvalid_out),
        .lsu_dccm_waddr      (lsu_dccm_waddr),
        .lsu_dccm_wen        (lsu_dccm_wen),
        .lsu_dccm_wdata      (lsu_dccm_wdata),
        .lsu_dccm_err        (lsu_dccm_err),
        .dma_req_valid       (dma_req_valid),
        .dma_req_ready       (dma_req_ready),
        .dma_req_we          (dma_req_we),
        .dma_req_addr        (dma_req_addr),
        .dma_req_wdata       (dma_req_wdata),
        .dma_rsp_valid       (dma_rsp_valid),
        .dma_rsp_rdata       (dma_rsp_rdata),
        .dma_rsp_err         (dma_rsp_err),
        .dma_starve          (dma_starve)
    );

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)       return BASE + 32'(4 * $urandom_range(0, 15));
        else if (r == 8) return OOR + 32'(4 * $urandom_range(0, 3));
        else             return BASE - 32'(4 * $urandom_range(1, 4));
    endfunction

    task automatic idle();
        lsu_dccm_rvalid_in = 1'b0;
        lsu_dccm_wen       = 1'b0;
        dma_req_valid      = 1'b0;
        dma_req_we         = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        lsu_dccm_raddr = BASE; lsu_dccm_waddr = BASE; lsu_dccm_wdata = '0;
        dma_req_addr = BASE; dma_req_wdata = '0;
        dma_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (lsu_dccm_rvalid_out !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%h exp=0", lsu_dccm_rvalid_out); end
        checks++; if (lsu_dccm_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", lsu_dccm_rdata); end
        checks++; if (lsu_dccm_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%h exp=0", lsu_dccm_err); end
        checks++; if (dma_req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%h exp=0", dma_req_ready); end
        checks++; if (dma_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%h exp=0", dma_rsp_valid); end
        checks++; if (dma_rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", dma_rsp_rdata); end
        checks++; if (dma_rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%h exp=0", dma_rsp_err); end
        checks++; if (dma_starve !== 1'b0) begin failures++; $display("FAIL rst_starve got=%h exp=0", dma_starve); end
        idle();
        rstn = 1'b1;
        @(negedge clk);
        exp_hold = '0;
    endtask

    task automatic test_dma_write_lsu_read();
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = BASE + 8; dma_req_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL dw_ready got=%h exp=1", dma_req_ready); end
        mem_m[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        idle();
        checks++; if (dma_rsp_valid !== 1'b1) begin failures++; $display("FAIL dw_rsp_valid got=%h exp=1", dma_rsp_valid); end
        checks++; if (dma_rsp_rdata !== 32'h0) begin failures++; $display("FAIL dw_rsp_rdata got=%h exp=0", dma_rsp_rdata); end
        checks++; if (dma_rsp_err !== 1'b0) begin failures++; $display("FAIL dw_rsp_err got=%h exp=0", dma_rsp_err); end
        lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = BASE + 8;
        @(negedge clk);
        idle();
        checks++; if (lsu_dccm_rvalid_out !== 1'b1) begin failures++; $display("FAIL lr_rvalid got=%h exp=1", lsu_dccm_rvalid_out); end
        checks++; if (lsu_dccm_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lr_rdata got=%h exp=deadbeef", lsu_dccm_rdata); end
        checks++; if (dma_rsp_valid !== 1'b0) begin failures++; $display("FAIL lr_rsp_valid got=%h exp=0", dma_rsp_valid); end
        @(negedge clk);
        checks++; if (lsu_dccm_rvalid_out !== 1'b0) begin failures++; $display("FAIL lr_rvalid_drop got=%h exp=0", lsu_dccm_rvalid_out); end
        checks++; if (lsu_dccm_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lr_rdata_hold got=%h exp=deadbeef", lsu_dccm_rdata); end
        exp_hold = 32'hDEAD_BEEF;
    endtask

    task automatic test_read_first();
        lsu_dccm_wen = 1'b1; lsu_dccm_waddr = BASE + 32'h40; lsu_dccm_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        lsu_dccm_wdata = 32'h1234_5678;
        lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = BASE + 32'h40;
        @(negedge clk);
        lsu_dccm_wen = 1'b0;
        checks++; if (lsu_dccm_rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL rf_old got=%h exp=a5a5a5a5", lsu_dccm_rdata); end
        checks++; if (lsu_dccm_err !== 1'b0) begin failures++; $display("FAIL rf_err got=%h exp=0", lsu_dccm_err); end
        @(negedge clk);
        idle();
        checks++; if (lsu_dccm_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rf_new got=%h exp=12345678", lsu_dccm_rdata); end
        mem_m[16] = 32'h1234_5678;
        exp_hold  = 32'h1234_5678;
    endtask

    task automatic test_starvation();
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = BASE + 8;
        lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = BASE + 32'h40;
        for (int i = 1; i <= 20; i++) begin
            #1;
            checks++; if (dma_req_ready !== 1'b0) begin failures++; $display("FAIL st_ready cyc=%0d got=%h exp=0", i, dma_req_ready); end
            checks++; if (dma_starve !== (i > LIMIT)) begin failures++; $display("FAIL st_starve cyc=%0d got=%h exp=%h", i, dma_starve, (i > LIMIT)); end
            @(negedge clk);
        end
        lsu_dccm_rvalid_in = 1'b0;
        #1;
        checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL st_accept got=%h exp=1", dma_req_ready); end
        checks++; if (dma_starve !== 1'b1) begin failures++; $display("FAIL st_starve_at_accept got=%h exp=1", dma_starve); end
        @(negedge clk);
        idle();
        checks++; if (dma_rsp_valid !== 1'b1) begin failures++; $display("FAIL st_rsp_valid got=%h exp=1", dma_rsp_valid); end
        checks++; if (dma_rsp_rdata !== mem_m[2]) begin failures++; $display("FAIL st_rsp_rdata got=%h exp=%h", dma_rsp_rdata, mem_m[2]); end
        checks++; if (dma_starve !== 1'b0) begin failures++; $display("FAIL st_starve_clear got=%h exp=0", dma_starve); end
        checks++; if (lsu_dccm_rdata !== mem_m[16]) begin failures++; $display("FAIL st_lsu_hold got=%h exp=%h", lsu_dccm_rdata, mem_m[16]); end
        @(negedge clk);
        checks++; if (dma_rsp_valid !== 1'b0) begin failures++; $display("FAIL st_single_rsp got=%h exp=0", dma_rsp_valid); end
        exp_hold = mem_m[16];
    endtask

    task automatic test_out_of_range();
        lsu_dccm_wen = 1'b1; lsu_dccm_waddr = BASE; lsu_dccm_wdata = 32'h0BAD_F00D;
        mem_m[0] = 32'h0BAD_F00D;
        @(negedge clk);
        idle();
        lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = OOR;
        @(negedge clk);
        idle();
        checks++; if (lsu_dccm_rvalid_out !== 1'b1) begin failures++; $display("FAIL oor_rvalid got=%h exp=1", lsu_dccm_rvalid_out); end
        checks++; if (lsu_dccm_rdata !== 32'h0) begin failures++; $display("FAIL oor_rdata got=%h exp=0", lsu_dccm_rdata); end
        checks++; if (lsu_dccm_err !== 1'b1) begin failures++; $display("FAIL oor_rd_err got=%h exp=1", lsu_dccm_err); end
        lsu_dccm_wen = 1'b1; lsu_dccm_waddr = OOR; lsu_dccm_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        idle();
        checks++; if (lsu_dccm_err !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%h exp=1", lsu_dccm_err); end
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = BASE;
        @(negedge clk);
        idle();
        checks++; if (lsu_dccm_err !== 1'b0) begin failures++; $display("FAIL oor_err_pulse got=%h exp=0", lsu_dccm_err); end
        checks++; if (dma_rsp_rdata !== mem_m[0]) begin failures++; $display("FAIL oor_no_write got=%h exp=%h", dma_rsp_rdata, mem_m[0]); end
        lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = BASE - 4;
        lsu_dccm_wen = 1'b1; lsu_dccm_waddr = OOR + 4; lsu_dccm_wdata = 32'h1111_2222;
        @(negedge clk);
        idle();
        checks++; if (lsu_dccm_err !== 1'b1) begin failures++; $display("FAIL oor_both_err got=%h exp=1", lsu_dccm_err); end
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = BASE - 8; dma_req_wdata = 32'h3333_4444;
        @(negedge clk);
        idle();
        checks++; if (lsu_dccm_err !== 1'b0) begin failures++; $display("FAIL oor_both_single got=%h exp=0", lsu_dccm_err); end
        checks++; if (dma_rsp_err !== 1'b1) begin failures++; $display("FAIL oor_dma_err got=%h exp=1", dma_rsp_err); end
        checks++; if (dma_rsp_rdata !== 32'h0) begin failures++; $display("FAIL oor_dma_rdata got=%h exp=0", dma_rsp_rdata); end
        exp_hold = '0;
    endtask

    task automatic test_wen_dma_read();
        lsu_dccm_wen = 1'b1; lsu_dccm_waddr = BASE + 32'h80; lsu_dccm_wdata = 32'hCAFE_F00D;
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = BASE + 8;
        #1;
        checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL wd_ready got=%h exp=1", dma_req_ready); end
        mem_m[32] = 32'hCAFE_F00D;
        @(negedge clk);
        dma_req_we = 1'b1; dma_req_addr = BASE + 12; dma_req_wdata = 32'h5555_AAAA;
        lsu_dccm_waddr = BASE + 32'h84; lsu_dccm_wdata = 32'h7777_8888;
        #1;
        checks++; if (dma_req_ready !== 1'b0) begin failures++; $display("FAIL wd_wr_blocked got=%h exp=0", dma_req_ready); end
        checks++; if (dma_rsp_valid !== 1'b1) begin failures++; $display("FAIL wd_rsp_valid got=%h exp=1", dma_rsp_valid); end
        checks++; if (dma_rsp_rdata !== mem_m[2]) begin failures++; $display("FAIL wd_rsp_rdata got=%h exp=%h", dma_rsp_rdata, mem_m[2]); end
        mem_m[33] = 32'h7777_8888;
        @(negedge clk);
        idle();
        lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = BASE + 32'h80;
        @(negedge clk);
        lsu_dccm_raddr = BASE + 32'h84;
        checks++; if (lsu_dccm_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL wd_lsu_write got=%h exp=cafef00d", lsu_dccm_rdata); end
        @(negedge clk);
        idle();
        checks++; if (lsu_dccm_rdata !== 32'h7777_8888) begin failures++; $display("FAIL wd_lsu_write2 got=%h exp=77778888", lsu_dccm_rdata); end
        exp_hold = 32'h7777_8888;
    endtask

    task automatic test_reset_mid();
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = BASE + 8;
        lsu_dccm_wen = 1'b1; lsu_dccm_waddr = OOR; lsu_dccm_wdata = 32'h0;
        #1;
        checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL rm_accept got=%h exp=1", dma_req_ready); end
        #2;
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (dma_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_rsp_valid got=%h exp=0", dma_rsp_valid); end
        checks++; if (lsu_dccm_err !== 1'b0) begin failures++; $display("FAIL rm_err got=%h exp=0", lsu_dccm_err); end
        checks++; if (lsu_dccm_rdata !== 32'h0) begin failures++; $display("FAIL rm_rdata got=%h exp=0", lsu_dccm_rdata); end
        checks++; if (dma_req_ready !== 1'b0) begin failures++; $display("FAIL rm_ready got=%h exp=0", dma_req_ready); end
        checks++; if (dma_starve !== 1'b0) begin failures++; $display("FAIL rm_starve got=%h exp=0", dma_starve); end
        idle();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (dma_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_late_rsp cyc=%0d got=%h exp=0", i, dma_rsp_valid); end
            checks++; if (lsu_dccm_rvalid_out !== 1'b0) begin failures++; $display("FAIL rm_late_rvalid cyc=%0d got=%h exp=0", i, lsu_dccm_rvalid_out); end
        end
        exp_hold = '0;
    endtask

    task automatic test_random();
        bit          exp_lsu_v, exp_lsu_err, exp_rsp_v, exp_rsp_err, exp_ready, prev_taken;
        logic [31:0] exp_rsp_rdata;
        int          wait_cnt;
        for (int i = 0; i < 16; i++) begin
            lsu_dccm_wen = 1'b1; lsu_dccm_waddr = BASE + 32'(4 * i); lsu_dccm_wdata = $urandom;
            mem_m[i] = lsu_dccm_wdata;
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        exp_lsu_v = 0; exp_lsu_err = 0; exp_rsp_v = 0; exp_rsp_err = 0; exp_rsp_rdata = '0;
        wait_cnt = 0; prev_taken = 1;
        for (int n = 0; n < 400; n++) begin
            checks++; if (lsu_dccm_rvalid_out !== exp_lsu_v) begin failures++; $display("FAIL rnd_rvalid n=%0d got=%h exp=%h", n, lsu_dccm_rvalid_out, exp_lsu_v); end
            checks++; if (lsu_dccm_rdata !== exp_hold) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, lsu_dccm_rdata, exp_hold); end
            checks++; if (lsu_dccm_err !== exp_lsu_err) begin failures++; $display("FAIL rnd_err n=%0d got=%h exp=%h", n, lsu_dccm_err, exp_lsu_err); end
            checks++; if (dma_rsp_valid !== exp_rsp_v) begin failures++; $display("FAIL rnd_rsp_valid n=%0d got=%h exp=%h", n, dma_rsp_valid, exp_rsp_v); end
            if (exp_rsp_v) begin
                checks++; if (dma_rsp_rdata !== exp_rsp_rdata) begin failures++; $display("FAIL rnd_rsp_rdata n=%0d got=%h exp=%h", n, dma_rsp_rdata, exp_rsp_rdata); end
                checks++; if (dma_rsp_err !== exp_rsp_err) begin failures++; $display("FAIL rnd_rsp_err n=%0d got=%h exp=%h", n, dma_rsp_err, exp_rsp_err); end
            end
            lsu_dccm_rvalid_in = ($urandom_range(0, 99) < 60);
            lsu_dccm_raddr     = rand_addr();
            lsu_dccm_wen       = ($urandom_range(0, 99) < 40);
            lsu_dccm_waddr     = rand_addr();
            lsu_dccm_wdata     = $urandom;
            if (prev_taken || !dma_req_valid) begin
                dma_req_valid = ($urandom_range(0, 99) < 70);
                dma_req_we    = $urandom_range(0, 1);
                dma_req_addr  = rand_addr();
                dma_req_wdata = $urandom;
            end
            #1;
            exp_ready = dma_req_valid && (dma_req_we ? !lsu_dccm_wen : !lsu_dccm_rvalid_in);
            checks++; if (dma_req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%h exp=%h", n, dma_req_ready, exp_ready); end
            checks++; if (dma_starve !== (wait_cnt == LIMIT)) begin failures++; $display("FAIL rnd_starve n=%0d got=%h exp=%h", n, dma_starve, (wait_cnt == LIMIT)); end
            wait_cnt = (dma_req_valid && !exp_ready) ? ((wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT) : 0;
            exp_lsu_v   = lsu_dccm_rvalid_in;
            exp_lsu_err = (lsu_dccm_rvalid_in && !in_rng(lsu_dccm_raddr)) || (lsu_dccm_wen && !in_rng(lsu_dccm_waddr));
            if (lsu_dccm_rvalid_in) exp_hold = in_rng(lsu_dccm_raddr) ? mem_m[idx_of(lsu_dccm_raddr)] : 32'h0;
            exp_rsp_v     = exp_ready;
            exp_rsp_err   = exp_ready && !in_rng(dma_req_addr);
            exp_rsp_rdata = (exp_ready && !dma_req_we && in_rng(dma_req_addr)) ? mem_m[idx_of(dma_req_addr)] : 32'h0;
            if (lsu_dccm_wen && in_rng(lsu_dccm_waddr)) mem_m[idx_of(lsu_dccm_waddr)] = lsu_dccm_wdata;
            if (exp_ready && dma_req_we && in_rng(dma_req_addr)) mem_m[idx_of(dma_req_addr)] = dma_req_wdata;
            prev_taken = exp_ready;
            @(negedge clk);
        end
        idle();
        checks++; if (lsu_dccm_rvalid_out !== exp_lsu_v) begin failures++; $display("FAIL rnd_last_rvalid got=%h exp=%h", lsu_dccm_rvalid_out, exp_lsu_v); end
        checks++; if (dma_rsp_valid !== exp_rsp_v) begin failures++; $display("FAIL rnd_last_rsp got=%h exp=%h", dma_rsp_valid, exp_rsp_v); end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dma_write_lsu_read();
        test_read_first();
        test_starvation();
        test_out_of_range();
        test_wen_dma_read();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
